// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcode and funct
// constants, FSM state encodings, ALU control codes and mux select codes.
package mips_multicycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUOp: how the ALU decoder chooses the operation
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RD2     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// Combinational ALU decoder: ALUOp plus the R-type funct field select the
// ALUControl code. Unknown funct values fall back to ADD.
module mips_alu_decoder
    import mips_multicycle_control_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // ALU operation select: fixed ADD/SUB or funct-driven for R-type
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore FSM control unit for the multicycle MIPS datapath.
// Optional feature macro: MIPS_CTRL_BNE_EN adds bne (opcode 05h) through the
// BRANCH state with an inverted taken condition; without it 05h is illegal.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    input  logic               Zero,
    output logic               IorD,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [2:0]         ALUControl,
    output logic [1:0]         PCSrc,
    output logic               PCEn,
    output logic               Branch,
    output logic               IllegalOp,
    output logic [STATE_W-1:0] State
);

    state_t     state;
    state_t     state_next;
    logic [1:0] aluop;
    logic [2:0] alu_ctl;
    logic       pcwrite;
    logic       taken;
    logic       op_legal;

    mips_alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (Funct),
        .alucontrol (alu_ctl)
    );

`ifdef MIPS_CTRL_BNE_EN
    logic is_bne;

    // Remember in DECODE whether the branch is bne so BRANCH needs no opcode
    always_ff @(posedge clk) begin
        if (reset)
            is_bne <= 1'b0;
        else if (state == S_DECODE)
            is_bne <= (Opcode == OP_BNE);
    end

    assign taken = is_bne ? ~Zero : Zero;
`else
    assign taken = Zero;
`endif

    // Opcodes the DECODE state knows how to dispatch
    always_comb begin
        case (Opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
`ifdef MIPS_CTRL_BNE_EN
            OP_BNE:  op_legal = 1'b1;
`endif
            default: op_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JUMP;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       state_next = S_BRANCH;
`endif
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_next = S_MEMWB;
            S_EXECUTE: state_next = S_ALUWB;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // Moore output decode; everything is held at zero while reset is high
    always_comb begin
        IorD      = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_RD2;
        aluop     = ALUOP_ADD;
        PCSrc     = PCSRC_ALURES;
        pcwrite   = 1'b0;
        Branch    = 1'b0;
        IllegalOp = 1'b0;
        case (state)
            S_FETCH: begin
                ALUSrcB = SRCB_FOUR;
                IRWrite = 1'b1;
                pcwrite = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB   = SRCB_IMM_SH2;
                IllegalOp = ~op_legal;
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: IorD = 1'b1;
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_ADDIWB: RegWrite = 1'b1;
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_BRANCH: begin
                ALUSrcA = 1'b1;
                aluop   = ALUOP_SUB;
                PCSrc   = PCSRC_ALUOUT;
                Branch  = 1'b1;
            end
            S_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                pcwrite = 1'b1;
            end
            default: ;
        endcase

        ALUControl = alu_ctl;
        PCEn       = pcwrite | (Branch & taken);

        if (reset) begin
            IorD       = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegDst     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            ALUSrcA    = 1'b0;
            ALUSrcB    = 2'b00;
            ALUControl = 3'b000;
            PCSrc      = 2'b00;
            PCEn       = 1'b0;
            Branch     = 1'b0;
            IllegalOp  = 1'b0;
        end
    end

    assign State = STATE_W'(state);

endmodule
